// File: rtl/soc_mem_pkg.sv
// Shared definitions for the memory copy/fill master: FSM states, command modes
// and the read latency of the attached single-port memory.
package soc_mem_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_WR,
        S_FWR,
        S_FIN
    } state_t;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    localparam int RD_LATENCY = 1;

endpackage

// File: rtl/soc_mem_addr_gen.sv
// Address generator: latches the command bases, walks a word index up or down
// (descending when an overlapping COPY would clobber unread source words),
// flags the last word and checks the command range without wrap-around.
module soc_mem_addr_gen
    import soc_mem_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 342
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              step,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   len,
    output logic              range_ok,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              last
);

    // Two guard bits so base+len can never wrap before the comparison.
    localparam int CW = ADDR_W + 2;
    localparam logic [CW-1:0] DEPTH_W = CW'(DEPTH);

    logic [CW-1:0]     src_w, dst_w, len_w, src_end, dst_end;
    logic              desc;
    logic [ADDR_W-1:0] src_q, dst_q, off_q;
    logic [ADDR_W:0]   cnt_q;
    logic              desc_q;

    assign src_w   = CW'(src_addr);
    assign dst_w   = CW'(dst_addr);
    assign len_w   = CW'(len);
    assign src_end = src_w + len_w;
    assign dst_end = dst_w + len_w;

    assign range_ok = ((mode == MODE_FILL) || (src_end <= DEPTH_W)) && (dst_end <= DEPTH_W);
    assign desc     = (mode == MODE_COPY) && (dst_w > src_w) && (dst_w < src_end);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_q  <= '0;
            dst_q  <= '0;
            off_q  <= '0;
            cnt_q  <= '0;
            desc_q <= 1'b0;
        end else if (load) begin
            src_q  <= src_addr;
            dst_q  <= dst_addr;
            desc_q <= desc;
            cnt_q  <= len;
            off_q  <= desc ? ADDR_W'(len - 1'b1) : '0;
        end else if (step) begin
            cnt_q <= cnt_q - 1'b1;
            off_q <= desc_q ? (off_q - 1'b1) : (off_q + 1'b1);
        end
    end

    assign rd_addr = src_q + off_q;
    assign wr_addr = dst_q + off_q;
    assign last    = (cnt_q == {{ADDR_W{1'b0}}, 1'b1});

endmodule

// File: rtl/soc_mem_copy_master.sv
// Avalon-MM master that copies (memmove-safe) or fills word ranges of a
// single-port on-chip memory and keeps a running checksum of written words.
module soc_mem_copy_master
    import soc_mem_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 342
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                mode,
    input  logic [ADDR_W-1:0]   src_addr,
    input  logic [ADDR_W-1:0]   dst_addr,
    input  logic [ADDR_W:0]     len,
    input  logic [DATA_W-1:0]   fill_data,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic                aborted,
    output logic [ADDR_W:0]     words_done,
    output logic [DATA_W-1:0]   checksum,
    output logic [ADDR_W-1:0]   m_address,
    output logic                m_chipselect,
    output logic                m_write,
    output logic [DATA_W/8-1:0] m_byteenable,
    output logic [DATA_W-1:0]   m_writedata,
    output logic                m_clken,
    input  logic [DATA_W-1:0]   m_readdata
);

    state_t                state_q, state_d;
    logic [DATA_W-1:0]     hold_q, hold_d;
    logic [DATA_W-1:0]     fill_q, fill_d;
    logic [DATA_W-1:0]     sum_q, sum_d;
    logic [ADDR_W:0]       words_q, words_d;
    logic                  error_q, error_d;
    logic                  aborted_q, aborted_d;
    logic                  zlen_q, zlen_d;
    logic [RD_LATENCY-1:0] rd_pipe_q;
    logic                  rd_now;
    logic                  ag_load, ag_step;
    logic                  range_ok, last;
    logic [ADDR_W-1:0]     rd_addr, wr_addr;

    soc_mem_addr_gen #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_addr_gen (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (ag_load),
        .step     (ag_step),
        .mode     (mode),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .range_ok (range_ok),
        .rd_addr  (rd_addr),
        .wr_addr  (wr_addr),
        .last     (last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            hold_q    <= '0;
            fill_q    <= '0;
            sum_q     <= '0;
            words_q   <= '0;
            error_q   <= 1'b0;
            aborted_q <= 1'b0;
            zlen_q    <= 1'b0;
            rd_pipe_q <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            fill_q    <= fill_d;
            sum_q     <= sum_d;
            words_q   <= words_d;
            error_q   <= error_d;
            aborted_q <= aborted_d;
            zlen_q    <= zlen_d;
            rd_pipe_q <= RD_LATENCY'({rd_pipe_q, rd_now});
        end
    end

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        fill_d       = fill_q;
        sum_d        = sum_q;
        words_d      = words_q;
        error_d      = 1'b0;
        aborted_d    = 1'b0;
        zlen_d       = 1'b0;
        ag_load      = 1'b0;
        ag_step      = 1'b0;
        rd_now       = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        m_chipselect = 1'b0;
        m_write      = 1'b0;
        m_address    = '0;
        m_writedata  = '0;

        case (state_q)
            S_IDLE: begin
                // A zero-length command resolves one cycle after start, with no bus traffic.
                if (zlen_q) begin
                    state_d = S_FIN;
                end else if (start) begin
                    if (!range_ok) begin
                        error_d = 1'b1;
                    end else if (len == '0) begin
                        zlen_d = 1'b1;
                    end else begin
                        ag_load = 1'b1;
                        fill_d  = fill_data;
                        sum_d   = '0;
                        words_d = '0;
                        state_d = (mode == MODE_FILL) ? S_FWR : S_RD;
                    end
                end
            end
            S_RD: begin
                busy         = 1'b1;
                m_chipselect = 1'b1;
                m_address    = rd_addr;
                rd_now       = 1'b1;
                state_d      = S_CAP;
            end
            S_CAP: begin
                busy = 1'b1;
                if (rd_pipe_q[RD_LATENCY-1]) begin
                    hold_d = m_readdata;
                end
                state_d = S_WR;
            end
            S_WR: begin
                busy         = 1'b1;
                m_chipselect = 1'b1;
                m_write      = 1'b1;
                m_address    = wr_addr;
                m_writedata  = hold_q;
                sum_d        = sum_q + hold_q;
                words_d      = words_q + 1'b1;
                if (last) begin
                    state_d = S_FIN;
                end else begin
                    ag_step = 1'b1;
                    state_d = S_RD;
                end
            end
            S_FWR: begin
                busy         = 1'b1;
                m_chipselect = 1'b1;
                m_write      = 1'b1;
                m_address    = wr_addr;
                m_writedata  = fill_q;
                sum_d        = sum_q + fill_q;
                words_d      = words_q + 1'b1;
                if (last) begin
                    state_d = S_FIN;
                end else begin
                    ag_step = 1'b1;
                end
            end
            S_FIN: begin
                done    = !abort;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // The write driven this cycle still lands and is counted; only the sequence stops.
        if (abort && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            aborted_d = 1'b1;
            ag_step   = 1'b0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DATA_W / 8; gi++) begin : g_be
            assign m_byteenable[gi] = m_chipselect;
        end
    endgenerate

    assign error      = error_q;
    assign aborted    = aborted_q;
    assign words_done = words_q;
    assign checksum   = sum_q;
    assign m_clken    = 1'b1;

endmodule

// File: tb/tb_soc_mem_copy_master.sv
// Scoreboard bench for soc_mem_copy_master: expected writes and completion
// events are queued at issue time and checked by an independent monitor.
module tb_soc_mem_copy_master;
    import soc_mem_pkg::*;

    localparam int AW    = 9;
    localparam int DW    = 32;
    localparam int DEPTH = 342;

    logic            clk;
    logic            reset_n;
    logic            start;
    logic            mode;
    logic [AW-1:0]   src_addr;
    logic [AW-1:0]   dst_addr;
    logic [AW:0]     len;
    logic [DW-1:0]   fill_data;
    logic            abort;
    logic            busy, done, error, aborted;
    logic [AW:0]     words_done;
    logic [DW-1:0]   checksum;
    logic [AW-1:0]   m_address;
    logic            m_chipselect, m_write, m_clken;
    logic [DW/8-1:0] m_byteenable;
    logic [DW-1:0]   m_writedata;
    logic [DW-1:0]   m_readdata;

    soc_mem_copy_master #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .mode         (mode),
        .src_addr     (src_addr),
        .dst_addr     (dst_addr),
        .len          (len),
        .fill_data    (fill_data),
        .abort        (abort),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .aborted      (aborted),
        .words_done   (words_done),
        .checksum     (checksum),
        .m_address    (m_address),
        .m_chipselect (m_chipselect),
        .m_write      (m_write),
        .m_byteenable (m_byteenable),
        .m_writedata  (m_writedata),
        .m_clken      (m_clken),
        .m_readdata   (m_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural single-port memory with one-clock read latency and a backdoor port.
    logic [DW-1:0] mem [0:DEPTH-1];
    logic          bd_we = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [DW-1:0] bd_data = '0;

    always @(posedge clk) begin
        if (bd_we)
            mem[bd_addr] <= bd_data;
        else if (m_chipselect && m_write && (int'(m_address) < DEPTH))
            mem[m_address] <= m_writedata;
        if (m_chipselect && !m_write && (int'(m_address) < DEPTH))
            m_readdata <= mem[m_address];
    end

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        int          kind;  // 0 done, 1 error, 2 aborted
        logic [AW:0] words;
        logic [DW-1:0] sum;
        int          at;
    } ev_t;

    wr_t wr_q[$];
    ev_t ev_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    bit  ign_wr = 1'b0;
    int  cs_cnt = 0;
    int  first_cs = -1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void push_wr(input int a, input logic [DW-1:0] d);
        wr_t w;
        w.addr = AW'(a);
        w.data = d;
        wr_q.push_back(w);
    endfunction

    function automatic void push_ev(input int kind, input int words, input logic [DW-1:0] sum, input int at);
        ev_t e;
        e.kind  = kind;
        e.words = (AW+1)'(words);
        e.sum   = sum;
        e.at    = at;
        ev_q.push_back(e);
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a write or a status pulse.
    initial begin
        wr_t w;
        ev_t e;
        int  kind;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (m_chipselect) begin
                    cs_cnt++;
                    if (first_cs < 0) first_cs = cyc;
                end
                if (m_chipselect && m_write && !ign_wr) begin
                    if (wr_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write", m_address, m_writedata);
                    end else begin
                        w = wr_q.pop_front();
                        chk("wr_addr", 64'(m_address), 64'(w.addr));
                        chk("wr_data", 64'(m_writedata), 64'(w.data));
                        chk("wr_byteenable", 64'(m_byteenable), 64'(4'hF));
                    end
                end
                if (done || error || aborted) begin
                    kind = done ? 0 : (error ? 1 : 2);
                    if (ev_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_event: got kind %0d, expected none", kind);
                    end else begin
                        e = ev_q.pop_front();
                        $display("event kind=%0d words_done=%0d checksum=0x%0h cycle=%0d", kind, words_done, checksum, cyc);
                        chk("ev_kind", 64'(kind), 64'(e.kind));
                        chk("ev_words_done", 64'(words_done), 64'(e.words));
                        chk("ev_checksum", 64'(checksum), 64'(e.sum));
                        if (e.at >= 0) chk("ev_cycle", 64'(cyc), 64'(e.at));
                    end
                end
            end
        end
    end

    task automatic poke(input int a, input logic [DW-1:0] d);
        @(posedge clk);
        #1;
        bd_we   = 1'b1;
        bd_addr = AW'(a);
        bd_data = d;
        @(posedge clk);
        #1;
        bd_we = 1'b0;
    endtask

    // Returns the index of the cycle in which start is high.
    task automatic issue(input logic md, input int s, input int d, input int n,
                         input logic [DW-1:0] f, output int k);
        @(posedge clk);
        #1;
        mode      = md;
        src_addr  = AW'(s);
        dst_addr  = AW'(d);
        len       = (AW+1)'(n);
        fill_data = f;
        start     = 1'b1;
        first_cs  = -1;
        k         = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int t = 0;
        while ((ev_q.size() != 0 || wr_q.size() != 0) && t < budget) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (ev_q.size() != 0 || wr_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_timeout: got %0d events and %0d writes outstanding, expected 0", name, ev_q.size(), wr_q.size());
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, expected the run to finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, c, cs0, t;
        logic [DW-1:0] s3;

        reset_n = 1'b0; start = 1'b0; mode = MODE_COPY; abort = 1'b0;
        src_addr = '0; dst_addr = '0; len = '0; fill_data = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_error", 64'(error), 64'(0));
        chk("rst_aborted", 64'(aborted), 64'(0));
        chk("rst_words_done", 64'(words_done), 64'(0));
        chk("rst_checksum", 64'(checksum), 64'(0));
        chk("rst_chipselect", 64'(m_chipselect), 64'(0));
        chk("rst_write", 64'(m_write), 64'(0));
        chk("rst_byteenable", 64'(m_byteenable), 64'(0));
        chk("rst_address", 64'(m_address), 64'(0));
        chk("rst_writedata", 64'(m_writedata), 64'(0));
        chk("rst_clken", 64'(m_clken), 64'(1));
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) poke(i, 32'hA5A5_0000 + i);
        for (int i = 0; i < 8; i++) poke(100 + i, 32'h0BAD_0000 + i);
        for (int i = 0; i < 5; i++) poke(10 + i, 32'(i + 1));

        // Abort once three COPY words have been written.
        issue(MODE_COPY, 0, 100, 8, '0, k);
        for (int i = 0; i < 3; i++) push_wr(100 + i, 32'hA5A5_0000 + i);
        s3 = 32'hA5A5_0000 * 3 + 3;
        t = 0;
        while (words_done != 3 && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("abort_reach3", 64'(words_done), 64'(3));
        c = cyc;
        push_ev(2, 3, s3, c + 1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        drain("abort", 20);
        chk("abort_busy", 64'(busy), 64'(0));
        for (int i = 0; i < 3; i++) chk("abort_mem_written", 64'(mem[100 + i]), 64'(32'hA5A5_0000 + i));
        for (int i = 3; i < 8; i++) chk("abort_mem_untouched", 64'(mem[100 + i]), 64'(32'h0BAD_0000 + i));

        // Plain ascending COPY 0..7 -> 100..107.
        issue(MODE_COPY, 0, 100, 8, '0, k);
        for (int i = 0; i < 8; i++) push_wr(100 + i, 32'hA5A5_0000 + i);
        push_ev(0, 8, 32'h2D28_001C, k + 25);
        drain("copy", 60);
        chk("copy_first_cs", 64'(first_cs), 64'(k + 1));
        for (int i = 0; i < 8; i++) chk("copy_mem", 64'(mem[100 + i]), 64'(32'hA5A5_0000 + i));

        // Overlapping COPY 10..14 -> 12..16 must run descending.
        issue(MODE_COPY, 10, 12, 5, '0, k);
        for (int i = 4; i >= 0; i--) push_wr(12 + i, 32'(i + 1));
        push_ev(0, 5, 32'd15, k + 16);
        drain("overlap", 40);
        for (int i = 0; i < 5; i++) chk("overlap_mem", 64'(mem[12 + i]), 64'(i + 1));

        // Range violation: no bus activity, counters untouched.
        cs0 = cs_cnt;
        issue(MODE_COPY, 340, 0, 3, '0, k);
        push_ev(1, 5, 32'd15, k + 1);
        drain("range_err", 10);
        chk("range_err_no_cs", 64'(cs_cnt), 64'(cs0));

        // FILL of the very last word is legal.
        issue(MODE_FILL, 0, 341, 1, 32'h1234_5678, k);
        push_wr(341, 32'h1234_5678);
        push_ev(0, 1, 32'h1234_5678, k + 2);
        drain("fill_last", 10);

        // Zero-length command.
        cs0 = cs_cnt;
        issue(MODE_COPY, 5, 5, 0, '0, k);
        push_ev(0, 1, 32'h1234_5678, k + 2);
        drain("len0", 10);
        chk("len0_no_cs", 64'(cs_cnt), 64'(cs0));

        // Full-memory FILL; a bad start mid-operation must be ignored.
        issue(MODE_FILL, 0, 0, DEPTH, 32'hDEAD_BEEF, k);
        for (int i = 0; i < DEPTH; i++) push_wr(i, 32'hDEAD_BEEF);
        push_ev(0, DEPTH, 32'hDEAD_BEEF * 32'd342, k + 343);
        repeat (5) @(posedge clk);
        #1;
        mode = MODE_COPY; src_addr = 9'd340; len = 10'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        drain("fill_all", 500);
        chk("fill_mem0", 64'(mem[0]), 64'(32'hDEAD_BEEF));
        chk("fill_mem341", 64'(mem[341]), 64'(32'hDEAD_BEEF));

        // Asynchronous reset in the middle of a FILL.
        ign_wr = 1'b1;
        issue(MODE_FILL, 0, 0, DEPTH, 32'h1357_9BDF, k);
        repeat (20) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_chipselect", 64'(m_chipselect), 64'(0));
        chk("arst_write", 64'(m_write), 64'(0));
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_words_done", 64'(words_done), 64'(0));
        chk("arst_checksum", 64'(checksum), 64'(0));
        chk("arst_byteenable", 64'(m_byteenable), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        ign_wr  = 1'b0;

        issue(MODE_COPY, 200, 300, 3, '0, k);
        for (int i = 0; i < 3; i++) push_wr(300 + i, 32'hDEAD_BEEF);
        push_ev(0, 3, 32'hDEAD_BEEF * 32'd3, k + 10);
        drain("post_reset", 30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
